// File: rtl/dir_input_debouncer_if.sv
// Button/command bundle between the raw push-button pins and the game controller.
// The master side drives the buttons and reads the command; the slave side is the conditioner.
interface dir_input_debouncer_if;
   logic [3:0] btn;
   logic [2:0] dir;
   logic [3:0] pressed;

   modport master (
      output btn,
      input  dir,
      input  pressed
   );

   modport slave (
      input  btn,
      output dir,
      output pressed
   );
endinterface

// File: rtl/dir_input_debouncer.sv
// Turns four raw direction buttons into single-cycle direction codes for the game controller,
// with per-button synchronise/debounce/edge-detect and a hold-off window after every command.
module dir_input_debouncer #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter int          DB_W            = 16,
   parameter logic [7:0]  HOLDOFF_CYCLES  = 8'd64,
   parameter int          HO_W            = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   dir_input_debouncer_if.slave  bus
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_EMIT    = 2'd1;
   localparam logic [1:0] ST_HOLDOFF = 2'd2;

   localparam logic [2:0]      DIR_IDLE = 3'b100;
   localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 16'd1);
   localparam logic [HO_W-1:0] HO_LAST  = HO_W'(HOLDOFF_CYCLES - 8'd1);

   logic [3:0]      sync_a;
   logic [3:0]      sync_b;
   logic [DB_W-1:0] db_cnt [4];
   logic [3:0]      pressed_q;
   logic [3:0]      pressed_d;
   logic [3:0]      rise;
   logic [3:0]      rise_q;
   logic [1:0]      state;
   logic [HO_W-1:0] ho_cnt;
   logic [2:0]      dir_q;
   logic [1:0]      winner;

   // Lowest index wins when several buttons rise together: up > down > left > right.
   function automatic logic [1:0] pick_winner(input logic [3:0] r);
      logic [1:0] idx;
      idx = 2'd3;
      for (int i = 3; i >= 0; i--) begin
         if (r[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   // Plain two-flop synchroniser, nothing between the stages.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= bus.btn;
         sync_b <= sync_a;
      end
   end

   // NOTE: the four debounce counters are individual flops, not a RAM, so they are reset like any register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
         pressed_q <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (sync_b[i] == pressed_q[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               pressed_q[i] <= sync_b[i];
               db_cnt[i]    <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Rising edges of the debounced levels only; releases never produce a command.
   // NOTE: combinational blocks assign every output first so no latch can be inferred.
   always_comb begin
      rise   = '0;
      winner = pick_winner(rise_q);
      rise   = pressed_q & ~pressed_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pressed_d <= '0;
         rise_q    <= '0;
      end else begin
         pressed_d <= pressed_q;
         rise_q    <= rise;
      end
   end

   // Command FSM: one registered code per accepted press, then a hold-off that discards rises.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         dir_q  <= DIR_IDLE;
         ho_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               dir_q <= DIR_IDLE;
               if (|rise_q) begin
                  state <= ST_EMIT;
                  dir_q <= {1'b0, winner};
               end
            end
            ST_EMIT: begin
               state  <= ST_HOLDOFF;
               dir_q  <= DIR_IDLE;
               ho_cnt <= '0;
            end
            ST_HOLDOFF: begin
               dir_q <= DIR_IDLE;
               if (ho_cnt == HO_LAST) begin
                  state <= ST_IDLE;
               end else begin
                  ho_cnt <= ho_cnt + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               dir_q <= DIR_IDLE;
            end
         endcase
      end
   end

   assign bus.dir     = dir_q;
   assign bus.pressed = pressed_q;

endmodule

// File: tb/tb_dir_input_debouncer.sv
// Scenario bench for dir_input_debouncer: expected pulses are queued when buttons are driven
// and matched by a negedge monitor that also enforces the dir invariants.
module tb_dir_input_debouncer;

   typedef struct {
      logic [2:0] code;
      int         at;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   last_pulse = -100;
   logic [2:0] prev_dir = 3'b100;
   exp_t sb[$];

   always #5 clk = ~clk;

   dir_input_debouncer_if bus ();

   dir_input_debouncer #(
      .DEBOUNCE_CYCLES (16'd4),
      .DB_W            (16),
      .HOLDOFF_CYCLES  (8'd8),
      .HO_W            (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Cycle k = value of cyc after the k-th negedge; buttons driven in cycle k pulse in cycle k+8.
   always @(negedge clk) begin
      exp_t e;
      cyc = cyc + 1;
      tests++;
      if (bus.dir > 3'd4) begin
         fails++;
         $display("FAIL dir_range cyc=%0d dir=%0d required<=4", cyc, bus.dir);
      end
      if (bus.dir < 3'd4) begin
         tests++;
         if (prev_dir < 3'd4) begin
            fails++;
            $display("FAIL dir_consecutive cyc=%0d dir=%0d prev=%0d required prev=4", cyc, bus.dir, prev_dir);
         end
         tests++;
         if (cyc - last_pulse < 9) begin
            fails++;
            $display("FAIL pulse_spacing cyc=%0d gap=%0d required>=9", cyc, cyc - last_pulse);
         end
         last_pulse = cyc;
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_pulse cyc=%0d dir=%0d required none", cyc, bus.dir);
         end else begin
            e = sb.pop_front();
            if (bus.dir !== e.code || cyc != e.at) begin
               fails++;
               $display("FAIL pulse cyc=%0d dir=%0d required cyc=%0d dir=%0d", cyc, bus.dir, e.at, e.code);
            end
         end
      end
      prev_dir = bus.dir;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      int k;
      int r;
      rst     = 1'b1;
      bus.btn = 4'b0000;
      tick(3);
      tests++;
      if (bus.dir !== 3'b100 || bus.pressed !== 4'b0000) begin
         fails++;
         $display("FAIL reset_state dir=%0d pressed=%b required dir=4 pressed=0000", bus.dir, bus.pressed);
      end
      rst = 1'b0;
      tick(5);
      bus.btn = 4'b0010;
      k = cyc;
      sb.push_back('{3'd1, k + 8});
      tick(8);
      tests++;
      if (bus.dir !== 3'd1) begin
         fails++;
         $display("FAIL pre_reset_pulse dir=%0d required 1", bus.dir);
      end
      #2 rst = 1'b1;
      #1;
      tests++;
      if (bus.dir !== 3'b100 || bus.pressed !== 4'b0000) begin
         fails++;
         $display("FAIL async_reset dir=%0d pressed=%b required dir=4 pressed=0000", bus.dir, bus.pressed);
      end
      tick(2);
      rst = 1'b0;
      r = cyc;
      sb.push_back('{3'd1, r + 8});
      tick(25);
      bus.btn = 4'b0000;
      tick(20);
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL reset_missing_pulse pending=%0d required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_clean_press();
      int k;
      k = cyc;
      bus.btn = 4'b0100;
      sb.push_back('{3'd2, k + 8});
      tick(5);
      tests++;
      if (bus.pressed[2] !== 1'b0) begin
         fails++;
         $display("FAIL press_early pressed2=%b required 0", bus.pressed[2]);
      end
      tick(1);
      tests++;
      if (bus.pressed[2] !== 1'b1) begin
         fails++;
         $display("FAIL press_level pressed2=%b required 1", bus.pressed[2]);
      end
      tick(44);
      bus.btn = 4'b0000;
      tick(5);
      tests++;
      if (bus.pressed[2] !== 1'b1) begin
         fails++;
         $display("FAIL release_early pressed2=%b required 1", bus.pressed[2]);
      end
      tick(1);
      tests++;
      if (bus.pressed[2] !== 1'b0) begin
         fails++;
         $display("FAIL release_level pressed2=%b required 0", bus.pressed[2]);
      end
      tick(20);
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL clean_missing_pulse pending=%0d required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_bounce();
      logic [4:0] pattern;
      pattern = 5'b10101;
      for (int i = 0; i < 5; i++) begin
         bus.btn[0] = pattern[i];
         if (i == 4) sb.push_back('{3'd0, cyc + 8});
         tick(1);
      end
      tick(30);
      bus.btn = 4'b0000;
      tick(20);
      for (int n = 1; n <= 3; n++) begin
         bus.btn[0] = 1'b1;
         tick(n);
         bus.btn[0] = 1'b0;
         tick(12);
      end
      tests++;
      if (bus.pressed !== 4'b0000) begin
         fails++;
         $display("FAIL glitch_level pressed=%b required 0000", bus.pressed);
      end
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL bounce_missing_pulse pending=%0d required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_simultaneous();
      bus.btn = 4'b1010;
      sb.push_back('{3'd1, cyc + 8});
      tick(7);
      tests++;
      if (bus.pressed !== 4'b1010) begin
         fails++;
         $display("FAIL simul_level pressed=%b required 1010", bus.pressed);
      end
      tick(25);
      bus.btn = 4'b0000;
      tick(20);
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL simul_missing_pulse pending=%0d required 0", sb.size());
         sb.delete();
      end
   endtask

   // A rise seen on the last hold-off cycle is dropped; one cycle later it is accepted.
   task automatic test_holdoff(input int late);
      int k0;
      k0 = cyc;
      bus.btn[3] = 1'b1;
      sb.push_back('{3'd3, k0 + 8});
      tick(3);
      bus.btn[0] = 1'b1;
      tick(late - 3);
      bus.btn[1] = 1'b1;
      if (late >= 10) sb.push_back('{3'd1, k0 + late + 8});
      tick(30);
      bus.btn = 4'b0000;
      tick(25);
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL holdoff_missing_pulse late=%0d pending=%0d required 0", late, sb.size());
         sb.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d required completion", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      rst     = 1'b1;
      bus.btn = 4'b0000;
      test_reset();
      test_clean_press();
      test_bounce();
      test_simultaneous();
      test_holdoff(9);
      test_holdoff(10);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
